alu_fwd_ctrl: RTL and testbench

- Pipeline control block for the EX-stage ALU operand selectors (operand A forward mux, operand B forward mux, and the immediate/register B select).
- Tracks destination registers of instructions in EX and MEM.
- Computes forwarding selects in ID and registers them into EX together with the ALU-immediate select.
- Detects load-use hazards and stalls the PC/IF-ID registers for one cycle while injecting a bubble.

---
 rtl/alu_fwd_ctrl.sv | 172 +++++++++++++++++
 tb/tb_alu_fwd_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_fwd_ctrl.sv
// Purpose : EX-stage ALU operand forwarding/immediate-select control with load-use stall.
// Latency : forward/aluimm selects appear on e_* one cycle after ID; stall is same-cycle combinational.
// Backpres: stall holds PC and IF/ID for one cycle and a bubble enters EX; MEM tracking always advances.
//
// Ports:
//   clk, clrn              pipeline clock (rising edge), asynchronous active-low reset
//   id_*                   decoded fields of the instruction currently in ID
//   flush                  kill the ID instruction (taken branch/jump); overrides stall
//   stall                  hold PC and IF/ID this cycle
//   e_fwda, e_fwdb         registered operand selects: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load
//   e_aluimm               registered B-select (1 = immediate), applied after the e_fwdb mux
//   e_wreg, e_m2reg, e_rn  registered EX-stage destination tracking
//   stall_cnt              saturating count of stall cycles (only with FWD_STALL_CNT_EN defined)
//
// Optional feature macro: FWD_STALL_CNT_EN

module alu_fwd_ctrl #(
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_aluimm,
  input  logic          id_wreg,
  input  logic          id_m2reg,
  input  logic [RW-1:0] id_rn,
  input  logic          flush,
`ifdef FWD_STALL_CNT_EN
  output logic [31:0]   stall_cnt,
`endif
  output logic          stall,
  output logic [1:0]    e_fwda,
  output logic [1:0]    e_fwdb,
  output logic          e_aluimm,
  output logic          e_wreg,
  output logic          e_m2reg,
  output logic [RW-1:0] e_rn
);

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_EXA  = 2'b01;
  localparam logic [1:0] FWD_MEMA = 2'b10;
  localparam logic [1:0] FWD_MEML = 2'b11;

  // EX copy
  logic          e_wreg_q, e_wreg_d;
  logic          e_m2reg_q, e_m2reg_d;
  logic [RW-1:0] e_rn_q, e_rn_d;
  logic [1:0]    e_fwda_q, e_fwda_d;
  logic [1:0]    e_fwdb_q, e_fwdb_d;
  logic          e_aluimm_q, e_aluimm_d;
  // MEM copy
  logic          m_wreg_q, m_wreg_d;
  logic          m_m2reg_q, m_m2reg_d;
  logic [RW-1:0] m_rn_q, m_rn_d;

  logic [1:0] fwda_id, fwdb_id;
  logic       bubble;

  // The newest producer (EX) wins over MEM. A load still in EX cannot
  // forward; that case is covered by the stall, so it falls through here.
  function automatic logic [1:0] fwd_sel(
    input logic          use_r,
    input logic [RW-1:0] r,
    input logic          ew,
    input logic          em,
    input logic [RW-1:0] ern,
    input logic          mw,
    input logic          mm,
    input logic [RW-1:0] mrn
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (!use_r || r == '0) begin
      sel = FWD_RF;
    end else if (ew && !em && ern == r) begin
      sel = FWD_EXA;
    end else if (mw && mrn == r) begin
      sel = mm ? FWD_MEML : FWD_MEMA;
    end
    return sel;
  endfunction

  always_comb begin
    fwda_id = fwd_sel(id_use_rs, id_rs, e_wreg_q, e_m2reg_q, e_rn_q,
                      m_wreg_q, m_m2reg_q, m_rn_q);
    fwdb_id = fwd_sel(id_use_rt, id_rt, e_wreg_q, e_m2reg_q, e_rn_q,
                      m_wreg_q, m_m2reg_q, m_rn_q);

    // Load in EX feeding the ID instruction: one-cycle hold, then MEM forwards load data.
    stall = id_valid & ~flush & e_wreg_q & e_m2reg_q & (e_rn_q != '0) &
            ((id_use_rs & (e_rn_q == id_rs)) | (id_use_rt & (e_rn_q == id_rt)));
    bubble = stall | flush | ~id_valid;

    e_wreg_d   = 1'b0;
    e_m2reg_d  = 1'b0;
    e_rn_d     = '0;
    e_fwda_d   = FWD_RF;
    e_fwdb_d   = FWD_RF;
    e_aluimm_d = 1'b0;
    if (!bubble) begin
      e_wreg_d   = id_wreg;
      e_m2reg_d  = id_m2reg;
      e_rn_d     = id_rn;
      e_fwda_d   = fwda_id;
      e_fwdb_d   = fwdb_id;
      e_aluimm_d = id_aluimm;
    end

    // MEM never stalls; it always takes whatever EX holds.
    m_wreg_d  = e_wreg_q;
    m_m2reg_d = e_m2reg_q;
    m_rn_d    = e_rn_q;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      e_wreg_q   <= 1'b0;
      e_m2reg_q  <= 1'b0;
      e_rn_q     <= '0;
      e_fwda_q   <= FWD_RF;
      e_fwdb_q   <= FWD_RF;
      e_aluimm_q <= 1'b0;
      m_wreg_q   <= 1'b0;
      m_m2reg_q  <= 1'b0;
      m_rn_q     <= '0;
    end else begin
      e_wreg_q   <= e_wreg_d;
      e_m2reg_q  <= e_m2reg_d;
      e_rn_q     <= e_rn_d;
      e_fwda_q   <= e_fwda_d;
      e_fwdb_q   <= e_fwdb_d;
      e_aluimm_q <= e_aluimm_d;
      m_wreg_q   <= m_wreg_d;
      m_m2reg_q  <= m_m2reg_d;
      m_rn_q     <= m_rn_d;
    end
  end

  assign e_wreg   = e_wreg_q;
  assign e_m2reg  = e_m2reg_q;
  assign e_rn     = e_rn_q;
  assign e_fwda   = e_fwda_q;
  assign e_fwdb   = e_fwdb_q;
  assign e_aluimm = e_aluimm_q;

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_fwd_ctrl.sv
module tb_alu_fwd_ctrl;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          clrn = 1'b0;
  logic          id_valid = 1'b0;
  logic [RW-1:0] id_rs = '0, id_rt = '0, id_rn = '0;
  logic          id_use_rs = 1'b0, id_use_rt = 1'b0, id_aluimm = 1'b0;
  logic          id_wreg = 1'b0, id_m2reg = 1'b0, flush = 1'b0;
  logic          stall, e_aluimm, e_wreg, e_m2reg;
  logic [1:0]    e_fwda, e_fwdb;
  logic [RW-1:0] e_rn;
`ifdef FWD_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  alu_fwd_ctrl #(.RW(RW)) dut (
    .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_aluimm(id_aluimm),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_rn(id_rn), .flush(flush),
`ifdef FWD_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .stall(stall), .e_fwda(e_fwda), .e_fwdb(e_fwdb), .e_aluimm(e_aluimm),
    .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_rn(e_rn)
  );

  // Reference model: an instruction in flight is described by what it writes.
  typedef struct {
    logic          wreg;
    logic          load;
    logic [RW-1:0] rn;
  } instr_t;

  typedef struct {
    logic          stall;
    logic [1:0]    fa, fb;
    logic          aluimm, wreg, m2reg;
    logic [RW-1:0] rn;
    logic [31:0]   cnt;
  } exp_t;

  exp_t        sb_q[$];
  instr_t      in_ex, in_mem;
  logic [1:0]  mdl_fa, mdl_fb;
  logic        mdl_imm;
  logic [31:0] mdl_cnt;
  logic        last_stall;
  logic        done = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Where does the newest value of register r live?
  function automatic logic [1:0] source_of(input logic used, input logic [RW-1:0] r,
                                           input instr_t ex, input instr_t mem);
    if (!used || r == 0) return 2'd0;
    if (ex.wreg && ex.rn == r && !ex.load) return 2'd1;
    if (mem.wreg && mem.rn == r) return mem.load ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  task automatic model_clear();
    in_ex = '{1'b0, 1'b0, '0};
    in_mem = '{1'b0, 1'b0, '0};
    mdl_fa = 2'd0; mdl_fb = 2'd0; mdl_imm = 1'b0; mdl_cnt = 32'd0;
  endtask

  function automatic exp_t snapshot(input logic st);
    exp_t e;
    e.stall = st; e.fa = mdl_fa; e.fb = mdl_fb; e.aluimm = mdl_imm;
    e.wreg = in_ex.wreg; e.m2reg = in_ex.load; e.rn = in_ex.rn; e.cnt = mdl_cnt;
    return e;
  endfunction

  // One ID-stage cycle: drive at negedge, predict, push expectation.
  task automatic step(input logic v, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                      input logic urs, input logic urt, input logic imm,
                      input logic wr, input logic ld, input logic [RW-1:0] rn,
                      input logic fl);
    logic   hz;
    instr_t nxt;
    @(negedge clk);
    clrn = 1'b1;
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_aluimm = imm; id_wreg = wr; id_m2reg = ld; id_rn = rn; flush = fl;
    hz = v && !fl && in_ex.wreg && in_ex.load && in_ex.rn != 0 &&
         ((urs && rs == in_ex.rn) || (urt && rt == in_ex.rn));
    sb_q.push_back(snapshot(hz));
    last_stall = hz;
    nxt = '{wr, ld, rn};
    if (hz || fl || !v) begin
      in_mem = in_ex;
      in_ex = '{1'b0, 1'b0, '0};
      mdl_fa = 2'd0; mdl_fb = 2'd0; mdl_imm = 1'b0;
    end else begin
      mdl_fa = source_of(urs, rs, in_ex, in_mem);
      mdl_fb = source_of(urt, rt, in_ex, in_mem);
      mdl_imm = imm;
      in_mem = in_ex;
      in_ex = nxt;
    end
    if (hz && mdl_cnt != 32'hFFFF_FFFF) mdl_cnt = mdl_cnt + 32'd1;
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clrn = 1'b0;
      id_valid = 1'($urandom); id_rs = RW'($urandom); id_rt = RW'($urandom);
      id_use_rs = 1'($urandom); id_use_rt = 1'($urandom); id_aluimm = 1'($urandom);
      id_wreg = 1'($urandom); id_m2reg = 1'($urandom); id_rn = RW'($urandom);
      flush = 1'($urandom);
      model_clear();
      last_stall = 1'b0;
      sb_q.push_back(snapshot(1'b0));
    end
  endtask

  // ALU op writing rd from rs,rt
  task automatic alu(input int rd, input int rs, input int rt, input logic fl = 1'b0);
    step(1'b1, RW'(rs), RW'(rt), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, RW'(rd), fl);
  endtask
  task automatic addi(input int rd, input int rs);
    step(1'b1, RW'(rs), RW'(0), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, RW'(rd), 1'b0);
  endtask
  task automatic lw(input int rd, input int rs);
    step(1'b1, RW'(rs), RW'(0), 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, RW'(rd), 1'b0);
  endtask
  task automatic nop();
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents stall and the EX selects.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!done) begin
        if (sb_q.size() == 0) begin
          chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
          e = sb_q.pop_front();
          chk("stall", {31'd0, stall}, {31'd0, e.stall});
          chk("e_fwda", {30'd0, e_fwda}, {30'd0, e.fa});
          chk("e_fwdb", {30'd0, e_fwdb}, {30'd0, e.fb});
          chk("e_aluimm", {31'd0, e_aluimm}, {31'd0, e.aluimm});
          chk("e_wreg", {31'd0, e_wreg}, {31'd0, e.wreg});
          chk("e_m2reg", {31'd0, e_m2reg}, {31'd0, e.m2reg});
          chk("e_rn", 32'(e_rn), 32'(e.rn));
`ifdef FWD_STALL_CNT_EN
          chk("stall_cnt", stall_cnt, e.cnt);
`endif
        end
      end
    end
  end

  initial begin
    logic          v, urs, urt, imm, wr, ld, fl;
    logic [RW-1:0] rs, rt, rn;
    model_clear();
    last_stall = 1'b0;
    v = 0; urs = 0; urt = 0; imm = 0; wr = 0; ld = 0; fl = 0; rs = 0; rt = 0; rn = 0;

    reset_cycles(3);
    // EX forward
    alu(3, 1, 2); alu(5, 3, 4);
    // MEM forward on both operands
    alu(3, 1, 2); nop(); alu(6, 3, 3);
    // EX beats MEM, r0 never forwarded
    alu(3, 1, 2); alu(3, 1, 2); alu(7, 3, 0);
    // load-use: stall, then the held instruction sees MEM load data
    lw(8, 1); alu(9, 8, 1); alu(9, 8, 1);
    // immediate B operand
    alu(3, 1, 2); addi(2, 3);
    // flush beats stall
    lw(8, 1); alu(9, 8, 1, 1'b1); nop();
    // load to r0 never stalls
    lw(0, 1); alu(9, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) reset_cycles(2);
      if (!last_stall) begin
        v = ($urandom_range(0, 9) != 0);
        rs = RW'($urandom_range(0, 7)); rt = RW'($urandom_range(0, 7));
        rn = RW'($urandom_range(0, 7));
        urs = 1'($urandom); urt = 1'($urandom); imm = 1'($urandom);
        wr = ($urandom_range(0, 3) != 0); ld = 1'($urandom);
        fl = ($urandom_range(0, 9) == 0);
      end else begin
        fl = ($urandom_range(0, 9) == 0);
      end
      step(v, rs, rt, urs, urt, imm, wr, ld, rn, fl);
    end

    @(negedge clk);
    done = 1'b1;
    #5;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
